// File: rtl/gc_response_decoder.sv
// Single-wire controller response decoder: measures low-pulse widths
// on the synchronized poll line and assembles a 64-bit frame.
module gc_response_decoder #(
    parameter int BIT_THRESH = 200,
    parameter int MIN_LOW    = 20,
    parameter int TIMEOUT    = 1000
) (
    input  logic        PCLK,
    input  logic        reset,
    input  logic        read,
    input  logic        poll,
    output logic [63:0] data_out,
    output logic [15:0] buttons,
    output logic [7:0]  stick_x,
    output logic [7:0]  stick_y,
    output logic        valid,
    output logic        error,
    output logic        busy
);

    localparam int CLOG = $clog2(TIMEOUT + 1);
    localparam int CW   = (CLOG > 11) ? CLOG : 11;

    localparam logic [CW-1:0] THRESH_C = CW'(BIT_THRESH);
    localparam logic [CW-1:0] MINLOW_C = CW'(MIN_LOW);
    localparam logic [CW-1:0] TO_C     = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_LOW,
        S_HIGH,
        S_STOP_WAIT,
        S_STOP_LOW,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    bitcnt_q, bitcnt_d;
    logic [63:0]   shift_q, shift_d;
    logic [63:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;

    logic          fall;
    logic          rise;
    logic          err;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        sync1_d = poll;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    assign fall    = prev_q & ~sync2_q;
    assign rise    = ~prev_q & sync2_q;
    assign cnt_inc = (cnt_q == TO_C) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_inc;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        err      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                bitcnt_d = '0;
                shift_d  = '0;
                if (read) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (cnt_q == TO_C) begin
                    err = 1'b1;
                end else if (rise) begin
                    if (cnt_q < MINLOW_C) begin
                        err = 1'b1;
                    end else begin
                        shift_d  = {shift_q[62:0], (cnt_q < THRESH_C)};
                        bitcnt_d = bitcnt_q + 7'd1;
                        cnt_d    = '0;
                        state_d  = (bitcnt_q == 7'd63) ? S_STOP_WAIT
                                                        : S_HIGH;
                    end
                end
            end
            S_HIGH: begin
                if (cnt_q == TO_C) begin
                    err = 1'b1;
                end else if (fall) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
                end
            end
            S_STOP_WAIT: begin
                if (cnt_q == TO_C) begin
                    err = 1'b1;
                end else if (fall) begin
                    cnt_d   = '0;
                    state_d = S_STOP_LOW;
                end
            end
            S_STOP_LOW: begin
                if (cnt_q == TO_C) begin
                    err = 1'b1;
                end else if (rise) begin
                    if (cnt_q >= MINLOW_C && cnt_q < THRESH_C) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            S_DONE: begin
                cnt_d = '0;
                if (!read) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        if (err) begin
            error_d  = 1'b1;
            shift_d  = '0;
            bitcnt_d = '0;
            cnt_d    = '0;
            state_d  = S_DONE;
        end

        // Losing the read window is a silent abort, not a frame error
        if (!read && state_q != S_IDLE && state_q != S_DONE) begin
            error_d  = 1'b0;
            valid_d  = 1'b0;
            data_d   = data_q;
            shift_d  = '0;
            bitcnt_d = '0;
            cnt_d    = '0;
            state_d  = S_IDLE;
        end
    end

    always_ff @(posedge PCLK) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign data_out = data_q;
    assign buttons  = data_q[63:48];
    assign stick_x  = data_q[47:40];
    assign stick_y  = data_q[39:32];
    assign valid    = valid_q;
    assign error    = error_q;
    assign busy     = (state_q == S_LOW) || (state_q == S_HIGH) ||
                      (state_q == S_STOP_LOW) || (state_q == S_STOP_WAIT);

endmodule

// File: tb/tb_gc_response_decoder.sv
// Directed bench for gc_response_decoder; a queue of expected
// valid/error events is checked by a pulse monitor.
module tb_gc_response_decoder;

    logic        PCLK;
    logic        reset;
    logic        read;
    logic        poll;
    logic [63:0] data_out;
    logic [15:0] buttons;
    logic [7:0]  stick_x;
    logic [7:0]  stick_y;
    logic        valid;
    logic        error;
    logic        busy;

    gc_response_decoder dut (
        .PCLK     (PCLK),
        .reset    (reset),
        .read     (read),
        .poll     (poll),
        .data_out (data_out),
        .buttons  (buttons),
        .stick_x  (stick_x),
        .stick_y  (stick_y),
        .valid    (valid),
        .error    (error),
        .busy     (busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   n_valid = 0;
    int   n_err   = 0;
    int   v0;
    int   e0;

    logic [63:0] f1 = 64'h1234_5678_9ABC_DEF0;
    logic [63:0] f2 = 64'hFEDC_BA98_0F0F_A55A;
    logic [63:0] f3 = 64'hA5A5_0000_FFFF_1234;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // slow: 0 = 300 low/100 high, 1 = 100 low/300 high
    // fast: 0 = 220 low/10 high, 1 = 30 low/10 high
    task automatic send_bit(input logic b, input bit slow);
        poll = 1'b0;
        if (slow) cyc(b ? 100 : 300);
        else      cyc(b ? 30 : 220);
        poll = 1'b1;
        if (slow) cyc(b ? 300 : 100);
        else      cyc(10);
    endtask

    task automatic send_bits(input logic [63:0] d, input int from,
                             input int n, input bit slow);
        for (int i = 0; i < n; i++) send_bit(d[63-from-i], slow);
    endtask

    task automatic send_stop(input int lo);
        poll = 1'b0;
        cyc(lo);
        poll = 1'b1;
        cyc(20);
    endtask

    task automatic new_window;
        read = 1'b0;
        cyc(5);
        read = 1'b1;
        cyc(5);
    endtask

    task automatic push(input logic e, input logic [63:0] d);
        exp_t x;
        x.err  = e;
        x.data = d;
        exp_q.push_back(x);
    endtask

    always @(negedge PCLK) begin
        if (valid || error) begin
            if (valid) n_valid++;
            if (error) n_err++;
            if (exp_q.size() == 0) begin
                check("unexpected pulse", {62'd0, valid, error}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse kind", {62'd0, valid, error},
                      mon_e.err ? 64'd1 : 64'd2);
                check("pulse data", data_out, mon_e.data);
            end
        end
    end

    initial begin
        reset = 1'b1;
        read  = 1'b0;
        poll  = 1'b1;
        cyc(3);
        @(negedge PCLK);
        check("rst data_out", data_out, 64'd0);
        check("rst valid", valid, 1'b0);
        check("rst error", error, 1'b0);
        check("rst busy", busy, 1'b0);
        reset = 1'b0;
        cyc(5);

        // good frame with slow timing
        read = 1'b1;
        cyc(5);
        push(1'b0, f1);
        v0 = n_valid;
        send_bits(f1, 0, 10, 1'b1);
        @(negedge PCLK);
        check("t1 busy mid", busy, 1'b1);
        send_bits(f1, 10, 54, 1'b1);
        send_stop(100);
        cyc(20);
        @(negedge PCLK);
        check("t1 valid count", 64'(n_valid - v0), 64'd1);
        check("t1 data_out", data_out, f1);
        check("t1 buttons", buttons, 16'h1234);
        check("t1 stick_x", stick_x, 8'h56);
        check("t1 stick_y", stick_y, 8'h78);
        check("t1 busy", busy, 1'b0);

        // 40 bits then line idles high -> timeout
        new_window();
        push(1'b1, f1);
        e0 = n_err;
        send_bits(f3, 0, 40, 1'b0);
        cyc(1100);
        @(negedge PCLK);
        check("t2 error count", 64'(n_err - e0), 64'd1);
        check("t2 data_out", data_out, f1);
        check("t2 busy", busy, 1'b0);

        // glitch at bit 5, then a good frame in the same window
        new_window();
        push(1'b1, f1);
        e0 = n_err;
        v0 = n_valid;
        send_bits(f3, 0, 5, 1'b0);
        poll = 1'b0;
        cyc(10);
        poll = 1'b1;
        cyc(30);
        @(negedge PCLK);
        check("t3 error count", 64'(n_err - e0), 64'd1);
        send_bits(f3, 0, 64, 1'b0);
        send_stop(100);
        cyc(20);
        @(negedge PCLK);
        check("t3 no valid", 64'(n_valid - v0), 64'd0);
        check("t3 data_out", data_out, f1);
        check("t3 busy", busy, 1'b0);

        // reset mid-frame, then recover with poll low at read rise
        new_window();
        send_bits(f2, 0, 30, 1'b0);
        reset = 1'b1;
        poll  = 1'b1;
        cyc(1);
        @(negedge PCLK);
        check("t4 rst data_out", data_out, 64'd0);
        check("t4 rst buttons", buttons, 16'd0);
        check("t4 rst stick_x", stick_x, 8'd0);
        check("t4 rst stick_y", stick_y, 8'd0);
        check("t4 rst valid", valid, 1'b0);
        check("t4 rst error", error, 1'b0);
        check("t4 rst busy", busy, 1'b0);
        reset = 1'b0;
        read  = 1'b0;
        poll  = 1'b0;
        cyc(5);
        read = 1'b1;
        cyc(30);
        @(negedge PCLK);
        check("t4 armed low", busy, 1'b0);
        poll = 1'b1;
        cyc(30);
        push(1'b0, f2);
        v0 = n_valid;
        send_bits(f2, 0, 64, 1'b0);
        send_stop(100);
        cyc(20);
        @(negedge PCLK);
        check("t4 valid count", 64'(n_valid - v0), 64'd1);
        check("t4 data_out", data_out, f2);
        check("t4 buttons", buttons, 16'hFEDC);
        check("t4 stick_x", stick_x, 8'hBA);
        check("t4 stick_y", stick_y, 8'h98);

        // read dropped at bit 20
        new_window();
        v0 = n_valid;
        e0 = n_err;
        send_bits(f3, 0, 20, 1'b0);
        @(negedge PCLK);
        check("t5 busy mid", busy, 1'b1);
        read = 1'b0;
        cyc(20);
        @(negedge PCLK);
        check("t5 busy", busy, 1'b0);
        check("t5 no valid", 64'(n_valid - v0), 64'd0);
        check("t5 no error", 64'(n_err - e0), 64'd0);
        check("t5 data_out", data_out, f2);

        // stop bit too long
        read = 1'b1;
        cyc(5);
        push(1'b1, f2);
        e0 = n_err;
        send_bits(f1, 0, 64, 1'b0);
        send_stop(300);
        cyc(20);
        @(negedge PCLK);
        check("t6 error count", 64'(n_err - e0), 64'd1);
        check("t6 data_out", data_out, f2);
        check("t6 busy", busy, 1'b0);

        check("pending events", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gc_response_decoder.md
GC_RESPONSE_DECODER -- requirements
Module: gc_response_decoder

Interface
REQ-001 SHALL have parameter BIT_THRESH, default 200: low-pulse length in PCLK cycles at or above which a bit decodes as 0; below it, the bit decodes as 1.
REQ-002 SHALL have parameter MIN_LOW, default 20: a low pulse shorter than this many cycles is a glitch.
REQ-003 SHALL have parameter TIMEOUT, default 1000: the maximum low or high interval, in cycles, allowed inside a frame.
REQ-004 SHALL have port PCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 SHALL have port read, input, 1 bit: high while the poll line is released for the controller response.
REQ-007 SHALL have port poll, input, 1 bit: the raw single-wire data line, asynchronous, idle high.
REQ-008 SHALL have port data_out, output, 64 bits: the last good frame, MSB = first bit received.
REQ-009 SHALL have port buttons, output, 16 bits: data_out[63:48].
REQ-010 SHALL have port stick_x, output, 8 bits: data_out[47:40].
REQ-011 SHALL have port stick_y, output, 8 bits: data_out[39:32].
REQ-012 SHALL have port valid, output, 1 bit: a 1-cycle pulse when a frame is accepted.
REQ-013 SHALL have port error, output, 1 bit: a 1-cycle pulse when a frame is aborted.
REQ-014 SHALL have port busy, output, 1 bit: high while a frame is in progress (states LOW, HIGH, STOP_LOW, STOP_WAIT).

Function
REQ-015 SHALL pass poll through a 2-flop synchronizer (reset value 1); all edge detection uses the synchronized signal, giving a fixed 2-cycle latency.
REQ-016 SHALL implement the states IDLE, ARMED, LOW, HIGH, STOP_WAIT, STOP_LOW and DONE.
REQ-017 SHALL transition IDLE->ARMED when read=1; while in ARMED, there is no timeout.
REQ-018 SHALL, on a falling edge, move ARMED->LOW and HIGH->LOW, clear the interval counter, and start counting the low interval.
REQ-019 SHALL, on a rising edge in LOW: if the low count < MIN_LOW, raise error; otherwise shift in bit (count<BIT_THRESH), increment the 7-bit bit counter, and go to HIGH, or to STOP_WAIT once the count reaches 64.
REQ-020 SHALL, in LOW or STOP_LOW, raise error if the low count reaches TIMEOUT; in HIGH or STOP_WAIT, raise error if the high count reaches TIMEOUT.
REQ-021 SHALL, on a falling edge in STOP_WAIT, go to STOP_LOW.
REQ-022 SHALL, on a rising edge in STOP_LOW, check the low count: if MIN_LOW <= count < BIT_THRESH, load data_out from the shift register, pulse valid in the next cycle, and go to DONE; otherwise raise error.
REQ-023 SHALL handle error as follows: pulse error for 1 cycle, discard the shift register, leave data_out unchanged, and go to DONE.
REQ-024 SHALL stay in DONE until read=0, then go to IDLE, so at most one frame is accepted per read window.
REQ-025 SHALL, on read going 0 in any state other than IDLE or DONE, abort to IDLE without raising error.
REQ-026 SHALL NOT assert valid and error in the same cycle.
REQ-027 SHALL saturate the interval counter (width >= 11 bits) at TIMEOUT and never wrap.
REQ-028 SHALL hold data_out and its derived fields between valid pulses.
REQ-029 SHALL, when read rises with poll already low, wait in ARMED for a high-then-falling edge.

Reset
REQ-030 SHALL, on reset=1 at a PCLK edge, set the state to IDLE, data_out=0, shift register=0, bit counter=0, interval counter=0, valid=0, error=0, busy=0, and synchronizer flops=1.
REQ-031 SHALL let reset override any in-progress frame; no valid or error pulse follows a reset.

Verification
REQ-032 SHALL cover: read=1; drive frame 0x1234_5678_9ABC_DEF0 (0 = 300 cycles low / 100 high, 1 = 100 low / 300 high) followed by a 100-cycle-low stop bit -> exactly one valid pulse; data_out=0x123456789ABCDEF0, buttons=0x1234, stick_x=0x56, stick_y=0x78.
REQ-033 SHALL cover: 40 bits sent, then the line held high for 1000 cycles -> error pulse; data_out retains its prior value; busy=0 after the error.
REQ-034 SHALL cover: a 10-cycle low glitch at bit 5 -> error pulse; a second good frame in the same read window -> ignored (state stays DONE).
REQ-035 SHALL cover: reset asserted at bit 30 -> all outputs 0 the next cycle; read low then high, then a good frame -> valid with correct data.
REQ-036 SHALL cover: read dropped at bit 20 -> return to IDLE with no error and no valid.
REQ-037 SHALL cover: a stop bit 300 cycles low -> error pulse; data_out unchanged.
